// File: rtl/instruction_fetch_unit_pkg.sv
// Shared fetch-stage definitions: NOP encoding, word size, default reset PC
// and the IF/ID pipeline record that the decode stage also consumes.
package instruction_fetch_unit_pkg;

    localparam int unsigned IFETCH_WIDTH     = 32;
    localparam int unsigned WORD_BYTES       = 4;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [IFETCH_WIDTH-1:0] instruction;
        logic [IFETCH_WIDTH-1:0] pcplus4;
        logic                    valid;
    } ifid_t;

endpackage

// File: rtl/instruction_fetch_unit_pc_register.sv
// Program counter: DATA_WIDTH register with load enable and asynchronous
// active-high reset to RESET_PC.
module pc_register
    import instruction_fetch_unit_pkg::*;
#(
    parameter int unsigned          DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC  = DEFAULT_RESET_PC
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] next_pc,
    output logic [DATA_WIDTH-1:0] pc
);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc <= RESET_PC;
        end else if (load) begin
            pc <= next_pc;
        end
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// MIPS-style fetch stage: PC, ROM address, IF/ID register, stall/redirect/flush.
// Optional sticky fetch-address check enabled by `define IFETCH_ADDR_CHECK_EN.
module instruction_fetch_unit
    import instruction_fetch_unit_pkg::*;
#(
    parameter int unsigned           DATA_WIDTH   = 32,
    parameter int unsigned           MEMORY_DEPTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC     = DEFAULT_RESET_PC
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  Stall,
    input  logic                  Redirect,
    input  logic [DATA_WIDTH-1:0] RedirectTarget,
    input  logic [DATA_WIDTH-1:0] Instruction,
    output logic [DATA_WIDTH-1:0] Address,
    output logic [DATA_WIDTH-1:0] IFID_Instruction,
    output logic [DATA_WIDTH-1:0] IFID_PCPlus4,
    output logic                  IFID_Valid,
    output logic                  AddrError
);

    localparam logic [DATA_WIDTH-1:0] ALIGN_MASK = ~DATA_WIDTH'(WORD_BYTES - 1);

    // Elaboration-time sanity checks on the configuration.
    if (RESET_PC[1:0] != 2'b00) begin : g_bad_reset_pc
        $error("RESET_PC must be word aligned");
    end
    if (MEMORY_DEPTH < 1) begin : g_bad_depth
        $error("MEMORY_DEPTH must be at least 1");
    end

    logic [DATA_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] pc_plus4;
    logic [DATA_WIDTH-1:0] next_pc;
    logic                  pc_load;
    logic                  fetch_halt;
    logic                  accept;
    ifid_t                 ifid_q;

    assign pc_plus4 = pc + DATA_WIDTH'(WORD_BYTES);
    assign Address  = pc;
    assign accept   = !Redirect && !Stall;

`ifdef IFETCH_ADDR_CHECK_EN
    localparam logic [DATA_WIDTH-3:0] MEM_WORDS = MEMORY_DEPTH[DATA_WIDTH-3:0];

    logic addr_bad;
    logic addr_error_q;

    assign addr_bad   = (pc[1:0] != 2'b00) || (pc[DATA_WIDTH-1:2] >= MEM_WORDS);
    // The detecting edge already refuses the fetch, not just later ones.
    assign fetch_halt = addr_error_q || addr_bad;
    assign AddrError  = addr_error_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_error_q <= 1'b0;
        end else if (accept && addr_bad) begin
            addr_error_q <= 1'b1;
        end
    end
`else
    assign fetch_halt = 1'b0;
    assign AddrError  = 1'b0;
`endif

    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned and infers a latch.
    always_comb begin
        pc_load = 1'b0;
        next_pc = pc;
        if (Redirect) begin
            pc_load = 1'b1;
            next_pc = RedirectTarget & ALIGN_MASK;
        end else if (!Stall && !fetch_halt) begin
            pc_load = 1'b1;
            next_pc = pc_plus4;
        end
    end

    pc_register #(
        .DATA_WIDTH (DATA_WIDTH),
        .RESET_PC   (RESET_PC)
    ) u_pc_register (
        .clk     (clk),
        .reset   (reset),
        .load    (pc_load),
        .next_pc (next_pc),
        .pc      (pc)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ifid_q <= '{instruction: NOP_INSTR, pcplus4: '0, valid: 1'b0};
        end else if (Redirect) begin
            ifid_q <= '{instruction: NOP_INSTR, pcplus4: '0, valid: 1'b0};
        end else if (!Stall) begin
            if (fetch_halt) begin
                ifid_q <= '{instruction: NOP_INSTR, pcplus4: '0, valid: 1'b0};
            end else begin
                ifid_q <= '{instruction: Instruction, pcplus4: pc_plus4, valid: 1'b1};
            end
        end
    end

    assign IFID_Instruction = ifid_q.instruction;
    assign IFID_PCPlus4     = ifid_q.pcplus4;
    assign IFID_Valid       = ifid_q.valid;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: directed steps plus random
// stall/redirect traffic against a fetch-stage reference model.
module tb_instruction_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_target;
    logic [31:0] instruction;
    logic [31:0] address;
    logic [31:0] ifid_instruction;
    logic [31:0] ifid_pcplus4;
    logic        ifid_valid;
    logic        addr_error;

    logic [31:0] rom [32];

    // Reference state: what decode should see and where fetch is pointing.
    logic [31:0] m_pc;
    logic [31:0] m_ins;
    logic [31:0] m_p4;
    logic        m_valid;
    logic        m_err;

    int tests  = 0;
    int failed = 0;

`ifdef IFETCH_ADDR_CHECK_EN
    localparam bit CHECK_EN = 1'b1;
`else
    localparam bit CHECK_EN = 1'b0;
`endif

    always #5 clk = ~clk;

    assign instruction = rom[address[6:2]];

    instruction_fetch_unit dut (
        .clk              (clk),
        .reset            (reset),
        .Stall            (stall),
        .Redirect         (redirect),
        .RedirectTarget   (redirect_target),
        .Instruction      (instruction),
        .Address          (address),
        .IFID_Instruction (ifid_instruction),
        .IFID_PCPlus4     (ifid_pcplus4),
        .IFID_Valid       (ifid_valid),
        .AddrError        (addr_error)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".addr"},  address,                  m_pc);
        check({tag, ".ins"},   ifid_instruction,         m_ins);
        check({tag, ".p4"},    ifid_pcplus4,             m_p4);
        check({tag, ".valid"}, {31'd0, ifid_valid},      {31'd0, m_valid});
        check({tag, ".err"},   {31'd0, addr_error},      {31'd0, m_err});
    endtask

    task automatic model_reset();
        m_pc = 32'h0; m_ins = 32'h0; m_p4 = 32'h0; m_valid = 1'b0; m_err = 1'b0;
    endtask

    function automatic bit out_of_range(input logic [31:0] pc);
        return (pc % 4 != 0) || (pc / 4 >= 32);
    endfunction

    // One clock: drive inputs, advance the model by the fetch rules, compare.
    task automatic step(input string tag, input bit s, input bit r, input logic [31:0] tgt);
        logic [31:0] fetched;
        stall = s; redirect = r; redirect_target = tgt;
        fetched = rom[(m_pc / 4) % 32];
        if (r) begin
            m_pc = (tgt / 4) * 4;
            m_ins = 32'h0; m_p4 = 32'h0; m_valid = 1'b0;
        end else if (!s) begin
            if (CHECK_EN && (m_err || out_of_range(m_pc))) begin
                m_err = 1'b1;
                m_ins = 32'h0; m_p4 = 32'h0; m_valid = 1'b0;
            end else begin
                m_ins = fetched; m_p4 = m_pc + 32'd4; m_valid = 1'b1;
                m_pc = m_pc + 32'd4;
            end
        end
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        #1;
        check_all("reset");
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        foreach (rom[i]) rom[i] = $urandom;
        stall = 1'b0; redirect = 1'b0; redirect_target = 32'h0;
        reset = 1'b1;
        model_reset();
        #2;
        check_all("reset_async");
        @(negedge clk);
        reset = 1'b0;

        // Free fetches A, B, C from word 0.
        step("free0", 0, 0, 0);
        step("free1", 0, 0, 0);
        step("free2", 0, 0, 0);

        // Stall holds PC and IF/ID, release captures the next word.
        step("stall0", 1, 0, 0);
        step("stall1", 1, 0, 0);
        step("unstall", 0, 0, 0);

        // Redirect beats stall; target low bits are dropped.
        step("redir_stall", 1, 1, 32'h13);
        step("after_redir", 0, 0, 0);

        // Back-to-back redirects keep IF/ID a bubble.
        step("redir_a", 0, 1, 32'h24);
        step("redir_b", 0, 1, 32'h08);
        step("after_redir2", 0, 0, 0);

        if (!CHECK_EN) begin
            // PC+4 wraps past the top of the address space.
            step("redir_top", 0, 1, 32'hFFFF_FFFF);
            step("wrap", 0, 0, 0);
            step("after_wrap", 0, 0, 0);
        end

        // Asynchronous reset mid-cycle while a real instruction is held.
        step("redir_18", 0, 1, 32'h18);
        step("at_1c", 0, 0, 0);
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        check_all("async_reset");
        @(negedge clk);
        reset = 1'b0;
        step("post_reset", 0, 0, 0);

        // Random stall/redirect traffic; targets stay inside program memory.
        for (int i = 0; i < 300; i++) begin
            bit s;
            bit r;
            logic [31:0] tgt;
            s = ($urandom_range(0, 3) == 0);
            r = ($urandom_range(0, 6) == 0);
            tgt = $urandom_range(0, 127);
            step("rand", s, r, tgt);
            if (CHECK_EN && m_err) begin
                do_reset();
            end
        end

        if (CHECK_EN) begin
            do_reset();
            step("redir_80", 0, 1, 32'h80);
            step("err_set", 0, 0, 0);
            step("err_hold", 0, 0, 0);
            step("redir_0", 0, 1, 32'h0);
            step("err_sticky", 0, 0, 0);
            step("err_stall", 1, 0, 0);
            do_reset();
            step("err_cleared", 0, 0, 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
